// File: rtl/scs8hd_ebufn_bus_ctrl.sv
// Drive-side controller for a shared tri-state bus made of WIDTH scs8hd_ebufn_1 cells.
// Accepts words from a valid/ready source and produces the per-bit data (A) and the
// common active-low enable (TEB). Data is set up one cycle before the enable falls,
// tenures are capped at MAX_BURST words, and TEB stays high for TURN_CYC cycles after
// each tenure before the bus can be driven again.
//
// Ports:
//   CLK          clock, rising edge
//   RESETB       synchronous active-low reset
//   req_valid    upstream word available
//   req_data     upstream word
//   req_last     final word of a burst
//   req_ready    word accepted this cycle (combinational)
//   bus_grant    arbiter permission to drive the bus
//   A            registered data to the ebufn A pins
//   TEB          registered enable to the ebufn TEB pins, 1 = high-Z
//   busy         registered, 1 when not idle
//   grant_lost   one-cycle pulse when a tenure is aborted by loss of grant
//   burst_split  one-cycle pulse when MAX_BURST ends a burst without req_last
module scs8hd_ebufn_bus_ctrl #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned TURN_CYC  = 2,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             CLK,
  input  logic             RESETB,
  input  logic             req_valid,
  input  logic [WIDTH-1:0] req_data,
  input  logic             req_last,
  output logic             req_ready,
  input  logic             bus_grant,
  output logic [WIDTH-1:0] A,
  output logic             TEB,
  output logic             busy,
  output logic             grant_lost,
  output logic             burst_split
);

  localparam int unsigned WcntW = $clog2(MAX_BURST + 1);
  localparam logic [WcntW-1:0] MaxBurst = WcntW'(MAX_BURST);
  localparam logic [3:0] TurnCyc = 4'(TURN_CYC);

  typedef enum logic [1:0] {StIdle, StSetup, StDrive, StRelease} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             last_q, last_d;
  logic [WcntW-1:0] wcnt_q, wcnt_d;
  logic [3:0]       tcnt_q, tcnt_d;
  logic             teb_q, teb_d;
  logic             busy_q, busy_d;
  logic             grant_lost_q, grant_lost_d;
  logic             burst_split_q, burst_split_d;
  logic             hs;

  assign hs = req_valid && req_ready;

  // State and registered outputs
  always_ff @(posedge CLK) begin
    if (!RESETB) begin
      state_q       <= StIdle;
      a_q           <= '0;
      last_q        <= 1'b0;
      wcnt_q        <= '0;
      tcnt_q        <= '0;
      teb_q         <= 1'b1;
      busy_q        <= 1'b0;
      grant_lost_q  <= 1'b0;
      burst_split_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      last_q        <= last_d;
      wcnt_q        <= wcnt_d;
      tcnt_q        <= tcnt_d;
      teb_q         <= teb_d;
      busy_q        <= busy_d;
      grant_lost_q  <= grant_lost_d;
      burst_split_q <= burst_split_d;
    end
  end

  // Next state and datapath
  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    last_d        = last_q;
    wcnt_d        = wcnt_q;
    tcnt_d        = tcnt_q;
    grant_lost_d  = 1'b0;
    burst_split_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        tcnt_d = '0;
        if (hs) begin
          state_d = StSetup;
          a_d     = req_data;
          last_d  = req_last;
          wcnt_d  = WcntW'(1);
        end
      end
      StSetup: begin
        if (!bus_grant) begin
          state_d      = StRelease;
          grant_lost_d = 1'b1;
          tcnt_d       = 4'd1;
        end else begin
          state_d = StDrive;
        end
      end
      StDrive: begin
        // Priority: grant loss, end of burst, burst cap, then accept a word.
        if (!bus_grant) begin
          state_d      = StRelease;
          grant_lost_d = 1'b1;
          tcnt_d       = 4'd1;
        end else if (last_q) begin
          state_d = StRelease;
          tcnt_d  = 4'd1;
        end else if (wcnt_q == MaxBurst) begin
          state_d       = StRelease;
          burst_split_d = 1'b1;
          tcnt_d        = 4'd1;
        end else if (hs) begin
          a_d    = req_data;
          last_d = req_last;
          wcnt_d = wcnt_q + WcntW'(1);
        end
      end
      StRelease: begin
        // A is held so the pins do not move while the buffers go high-Z.
        if (tcnt_q >= TurnCyc) begin
          state_d = StIdle;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: ready is combinational, the rest are registered from the next state
  always_comb begin
    req_ready = ((state_q == StIdle) && bus_grant) ||
                ((state_q == StDrive) && !last_q && (wcnt_q < MaxBurst) && bus_grant);
    teb_d     = (state_d != StDrive);
    busy_d    = (state_d != StIdle);
  end

  assign A           = a_q;
  assign TEB         = teb_q;
  assign busy        = busy_q;
  assign grant_lost  = grant_lost_q;
  assign burst_split = burst_split_q;

endmodule

// File: tb/tb_scs8hd_ebufn_bus_ctrl.sv
// Scoreboard bench for scs8hd_ebufn_bus_ctrl. Stimulus pushes the expected bus word for
// every cycle TEB should be low, plus expected pulse events; a monitor pops and compares.
module tb_scs8hd_ebufn_bus_ctrl;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned TURN_CYC  = 2;
  localparam int unsigned MAX_BURST = 4;

  logic             CLK = 1'b0;
  logic             RESETB;
  logic             req_valid;
  logic [WIDTH-1:0] req_data;
  logic             req_last;
  logic             req_ready;
  logic             bus_grant;
  logic [WIDTH-1:0] A;
  logic             TEB;
  logic             busy;
  logic             grant_lost;
  logic             burst_split;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_a[$];
  int               exp_evt[$];   // 1 = grant_lost, 2 = burst_split

  scs8hd_ebufn_bus_ctrl #(
    .WIDTH    (WIDTH),
    .TURN_CYC (TURN_CYC),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .CLK        (CLK),
    .RESETB     (RESETB),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .bus_grant  (bus_grant),
    .A          (A),
    .TEB        (TEB),
    .busy       (busy),
    .grant_lost (grant_lost),
    .burst_split(burst_split)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Present a word and wait (bounded) for the handshake; returns 1 ns after that edge.
  task automatic send(input logic [WIDTH-1:0] d, input logic l);
    bit hs = 0;
    int n  = 0;
    req_valid = 1'b1;
    req_data  = d;
    req_last  = l;
    while (!hs && n < 50) begin
      @(negedge CLK);
      hs = req_ready;
      @(posedge CLK);
      #1;
      n++;
    end
    checks++;
    if (!hs) begin
      errors++;
      $display("FAIL handshake_timeout got none want word %0h", d);
    end
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Monitor: bus words while TEB is low, setup before enable, turnaround gap, pulses.
  initial begin
    logic             prev_teb = 1'b1;
    logic [WIDTH-1:0] prev_a   = '0;
    int               high_run = 0;
    bit               seen     = 0;
    forever begin
      @(negedge CLK);
      if (TEB === 1'b0) begin
        if (prev_teb) begin
          checks++;
          if (A !== prev_a) begin
            errors++;
            $display("FAIL setup_before_enable got %0h want %0h", A, prev_a);
          end
          if (seen) begin
            checks++;
            if (high_run < int'(TURN_CYC + 1)) begin
              errors++;
              $display("FAIL turnaround_gap got %0d want >= %0d", high_run, TURN_CYC + 1);
            end
          end
          seen = 1;
        end
        checks++;
        if (exp_a.size() == 0) begin
          errors++;
          $display("FAIL unexpected_drive got %0h want TEB high", A);
        end else begin
          logic [WIDTH-1:0] w;
          w = exp_a.pop_front();
          if (A !== w) begin
            errors++;
            $display("FAIL bus_word got %0h want %0h", A, w);
          end
        end
        high_run = 0;
      end else begin
        high_run++;
      end
      if (grant_lost || burst_split) begin
        int code;
        code = (grant_lost ? 1 : 0) + (burst_split ? 2 : 0);
        checks++;
        if (exp_evt.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse got %0d want none", code);
        end else begin
          int e;
          e = exp_evt.pop_front();
          if (code != e) begin
            errors++;
            $display("FAIL pulse_kind got %0d want %0d", code, e);
          end
        end
      end
      prev_teb = TEB;
      prev_a   = A;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    RESETB    = 1'b0;
    bus_grant = 1'b0;
    req_valid = 1'b0;
    req_data  = '0;
    req_last  = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_teb", TEB, 1);
    chk("rst_a", A, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_grant_lost", grant_lost, 0);
    chk("rst_burst_split", burst_split, 0);
    @(posedge CLK);
    #1;
    RESETB    = 1'b1;
    bus_grant = 1'b1;
    idle(2);

    // Single word: setup cycle, one drive cycle, two release cycles, idle.
    exp_a.push_back(8'hA5);
    send(8'hA5, 1'b1);
    req_valid = 1'b0;
    @(negedge CLK);
    chk("single_setup_teb", TEB, 1);
    chk("single_setup_a", A, 8'hA5);
    @(negedge CLK);
    chk("single_drive_teb", TEB, 0);
    @(negedge CLK);
    chk("single_rel1_teb", TEB, 1);
    chk("single_rel1_busy", busy, 1);
    @(negedge CLK);
    chk("single_rel2_teb", TEB, 1);
    chk("single_rel2_busy", busy, 1);
    @(negedge CLK);
    chk("single_idle_busy", busy, 0);
    idle(2);

    // Three-word burst without stalls.
    exp_a.push_back(8'h11);
    exp_a.push_back(8'h22);
    exp_a.push_back(8'h33);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b1);
    @(negedge CLK);
    chk("burst_ready_after_last", req_ready, 0);
    req_valid = 1'b0;
    idle(5);
    chk("burst_drained", exp_a.size(), 0);

    // Upstream stall: 0x11 held for three drive cycles before 0x22 arrives.
    exp_a.push_back(8'h11);
    exp_a.push_back(8'h11);
    exp_a.push_back(8'h11);
    exp_a.push_back(8'h22);
    send(8'h11, 1'b0);
    idle(3);
    send(8'h22, 1'b1);
    idle(5);
    chk("stall_drained", exp_a.size(), 0);

    // Six words, no last until word 6: cap splits after word 4.
    for (int i = 1; i <= 6; i++) exp_a.push_back(8'(i));
    exp_evt.push_back(2);
    for (int i = 1; i <= 6; i++) send(8'(i), (i == 6));
    idle(6);
    chk("split_drained", exp_a.size(), 0);
    chk("split_evt_drained", exp_evt.size(), 0);

    // Grant dropped after word 2; word 3 waits and is resent once grant returns.
    exp_a.push_back(8'h41);
    exp_a.push_back(8'h42);
    exp_a.push_back(8'h43);
    exp_evt.push_back(1);
    send(8'h41, 1'b0);
    send(8'h42, 1'b0);
    bus_grant = 1'b0;
    req_data  = 8'h43;
    req_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("gl_ready_low", req_ready, 0);
    end
    @(posedge CLK);
    #1;
    bus_grant = 1'b1;
    send(8'h43, 1'b1);
    req_valid = 1'b0;
    @(negedge CLK);
    chk("gl_resend_setup_teb", TEB, 1);
    chk("gl_resend_setup_a", A, 8'h43);
    idle(5);
    chk("gl_drained", exp_a.size(), 0);
    chk("gl_evt_drained", exp_evt.size(), 0);

    // Reset while driving.
    exp_a.push_back(8'h77);
    send(8'h77, 1'b0);
    req_valid = 1'b0;
    @(posedge CLK);
    #1;
    RESETB = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("rst_drive_teb", TEB, 1);
    chk("rst_drive_busy", busy, 0);
    chk("rst_drive_a", A, 0);
    @(posedge CLK);
    #1;
    RESETB = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("post_rst_teb", TEB, 1);
    end
    chk("final_words_drained", exp_a.size(), 0);
    chk("final_evts_drained", exp_evt.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
